wb_port_arbiter: RTL



---
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// writeback stage and a debug/loader requester. The pipeline has priority.
// A starvation counter forces a one-cycle stall so a pending debug write
// always completes. A shadow of the last committed write feeds the HEX decoders.
module wb_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WB_EN,
  input  logic [ADDR_W-1:0] WB_DR,
  input  logic [DATA_W-1:0] WB_val,
  input  logic              DBG_REQ,
  input  logic [ADDR_W-1:0] DBG_DR,
  input  logic [DATA_W-1:0] DBG_DATA,
  output logic              DBG_ACK,
  output logic              STALL,
  output logic              RF_WE,
  output logic [ADDR_W-1:0] RF_WA,
  output logic [DATA_W-1:0] RF_WD,
  output logic [DATA_W-1:0] LAST_VAL,
  output logic              LAST_SRC
);

  localparam int CNT_W = $clog2(STARVE_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] hold_dr;
  logic [DATA_W-1:0] hold_data;
  logic              pipe_commit;
  logic              dbg_commit;

  // Decide which requester owns the write port this cycle.
  always_comb begin
    pipe_commit = 1'b0;
    dbg_commit  = 1'b0;
    case (state)
      S_IDLE:  pipe_commit = WB_EN;
      S_PEND: begin
        pipe_commit = WB_EN;
        dbg_commit  = ~WB_EN;
      end
      // Writeback is frozen by STALL here, so WB_EN is ignored and replays later.
      S_FORCE: dbg_commit = 1'b1;
      S_ACK:   pipe_commit = WB_EN;
      default: begin
        pipe_commit = 1'b0;
        dbg_commit  = 1'b0;
      end
    endcase
  end

  // Arbitration state, starvation counter, debug hold registers and handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold_dr   <= '0;
      hold_data <= '0;
      STALL     <= 1'b0;
      DBG_ACK   <= 1'b0;
    end else begin
      STALL   <= 1'b0;
      DBG_ACK <= dbg_commit;
      case (state)
        S_IDLE: begin
          if (DBG_REQ) begin
            hold_dr   <= DBG_DR;
            hold_data <= DBG_DATA;
            cnt       <= '0;
            state     <= S_PEND;
          end
        end
        S_PEND: begin
          if (!WB_EN) begin
            state <= S_ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= S_FORCE;
              STALL <= 1'b1;
            end
          end
        end
        S_FORCE: state <= S_ACK;
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register-file write port and last-write shadow; address/data hold when idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RF_WE    <= 1'b0;
      RF_WA    <= '0;
      RF_WD    <= '0;
      LAST_VAL <= '0;
      LAST_SRC <= 1'b0;
    end else begin
      RF_WE <= pipe_commit | dbg_commit;
      if (dbg_commit) begin
        RF_WA    <= hold_dr;
        RF_WD    <= hold_data;
        LAST_VAL <= hold_data;
        LAST_SRC <= 1'b1;
      end else if (pipe_commit) begin
        RF_WA    <= WB_DR;
        RF_WD    <= WB_val;
        LAST_VAL <= WB_val;
        LAST_SRC <= 1'b0;
      end
    end
  end

endmodule
